period_meter: RTL and testbench

Measures the period and high time of a slow square-wave input in `clk` cycles. It is the receiving counterpart of the free-running clock divider: it takes a divided strobe, either local or from another board, and checks its rate and duty. It also reports lock and loss-of-signal. It sits beside the LED/command indication logic and supervises divided-clock and blink strobes.

---
 rtl/period_meter.sv | 172 +++++++++++++++++
 tb/tb_period_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter
//
// Measures the rise-to-rise period and rise-to-fall high time of a slow,
// asynchronous square wave in clk cycles, reports when the period has been
// stable for LOCK_COUNT consecutive measurements, and flags loss of signal
// when no rising edge arrives within TIMEOUT cycles.
//
// Ports:
//   clk          system clock, all state on its rising edge
//   rst_n        asynchronous active-low reset
//   sig_in_i     measured signal, asynchronous to clk
//   period_o     last measured rise-to-rise distance (clk cycles)
//   high_time_o  rise-to-fall distance within that same period
//   valid_o      one-cycle pulse marking a new period/high_time pair
//   locked_o     period has been identical for LOCK_COUNT measurements
//   timeout_o    loss of signal, sticky until the next rising edge

module period_meter #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sig_in_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_time_o,
    output logic                 valid_o,
    output logic                 locked_o,
    output logic                 timeout_o
);

    localparam int unsigned MatchWidth = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_WIDTH-1:0]  CntOne      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  TimeoutVal  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0]  TimeoutLast = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [MatchWidth-1:0] MatchOne    = MatchWidth'(1);
    localparam logic [MatchWidth-1:0] LockVal     = MatchWidth'(LOCK_COUNT);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StMeasure = 2'd1;
    localparam logic [1:0] StLocked  = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   sig_s;
    logic                   rise;
    logic                   fall;

    logic [1:0]            state_q,  state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
    logic [CNT_WIDTH-1:0]  hi_cap_q, hi_cap_d;
    logic [MatchWidth-1:0] match_q,  match_d;
    logic [MatchWidth-1:0] match_next;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic [CNT_WIDTH-1:0]  high_q,   high_d;
    logic                  valid_q,  valid_d;
    logic                  locked_q, locked_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  meas;

    // Synchroniser followed by one edge-detect flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in_i};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~edge_q;
    assign fall  = ~sig_s & edge_q;

    // cnt counts cycles since the last rise, so the distance to the current
    // cycle inclusive is cnt + 1.
    assign meas = cnt_q + CntOne;

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        match_next = MatchOne;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;

        // Saturating counter; never wraps so a dead input cannot alias.
        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q != TimeoutVal) begin
            cnt_d = meas;
        end else begin
            cnt_d = cnt_q;
        end

        hi_cap_d = fall ? meas : hi_cap_q;

        if (rise) begin
            if (state_q == StIdle) begin
                // Arming rise: no reference edge yet, so nothing to report.
                state_d   = StMeasure;
                match_d   = '0;
                timeout_d = 1'b0;
            end else begin
                valid_d  = 1'b1;
                period_d = meas;
                high_d   = hi_cap_q;

                // match_q == 0 marks the first measurement after arming.
                if (match_q == '0 || meas != period_q) begin
                    match_next = MatchOne;
                end else if (match_q != LockVal) begin
                    match_next = match_q + MatchOne;
                end else begin
                    match_next = match_q;
                end
                match_d = match_next;

                if (match_next == LockVal) begin
                    state_d  = StLocked;
                    locked_d = 1'b1;
                end else begin
                    state_d  = StMeasure;
                    locked_d = 1'b0;
                end
            end
        end else if (state_q != StIdle && cnt_q == TimeoutLast) begin
            // Loss of signal; period/high_time keep their last values.
            state_d   = StIdle;
            match_d   = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_cap_q  <= '0;
            match_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            match_q   <= match_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o    = period_q;
    assign high_time_o = high_q;
    assign valid_o     = valid_q;
    assign locked_o    = locked_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
//
// Drives square waves (directed and random) into period_meter and compares
// every output on every cycle against a timestamp-based reference: periods
// and high times are differences of edge indices, lock is a run length of
// equal periods, loss of signal is a gap of TIMEOUT indices without a rise.
// Model results are delayed by the synchroniser latency before comparison.

module tb_period_meter;

    localparam int unsigned CNT_WIDTH   = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT     = 1000;
    localparam int unsigned LOCK_COUNT  = 4;
    localparam int          LAT         = SYNC_STAGES + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 sig_in;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;
    logic                 valid;
    logic                 locked;
    logic                 timeout;

    period_meter #(
        .CNT_WIDTH   (CNT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT),
        .LOCK_COUNT  (LOCK_COUNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_in_i    (sig_in),
        .period_o    (period),
        .high_time_o (high_time),
        .valid_o     (valid),
        .locked_o    (locked),
        .timeout_o   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [CNT_WIDTH-1:0] period;
        logic [CNT_WIDTH-1:0] high;
        logic                 valid;
        logic                 locked;
        logic                 timeout;
    } exp_t;

    exp_t pipe[$];

    int total = 0;
    int bad   = 0;
    int idx   = 0;

    // Reference model state, in terms of input sample indices.
    logic                 m_prev;
    logic                 m_armed;
    int                   m_rise;
    int                   m_fall;
    int                   m_match;
    logic [CNT_WIDTH-1:0] m_period;
    logic [CNT_WIDTH-1:0] m_high;
    logic                 m_valid;
    logic                 m_locked;
    logic                 m_timeout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (sample %0d)", tag, obs, exp, idx);
        end
    endtask

    task automatic model_clear();
        exp_t z;
        z = '{period: '0, high: '0, valid: 1'b0, locked: 1'b0, timeout: 1'b0};
        m_prev    = 1'b0;
        m_armed   = 1'b0;
        m_rise    = 0;
        m_fall    = 0;
        m_match   = 0;
        m_period  = '0;
        m_high    = '0;
        m_valid   = 1'b0;
        m_locked  = 1'b0;
        m_timeout = 1'b0;
        pipe.delete();
        for (int k = 0; k < LAT; k++) pipe.push_back(z);
    endtask

    // One clock: compare outputs, then feed the next input sample.
    task automatic step(input logic x);
        exp_t e;
        logic r;
        logic f;
        int   p;
        @(posedge clk);
        #1;
        e = pipe.pop_front();
        check("period",    32'(period),    32'(e.period));
        check("high_time", 32'(high_time), 32'(e.high));
        check("valid",     32'(valid),     32'(e.valid));
        check("locked",    32'(locked),    32'(e.locked));
        check("timeout",   32'(timeout),   32'(e.timeout));

        r = x & ~m_prev;
        f = ~x & m_prev;
        m_valid = 1'b0;
        if (r) begin
            if (!m_armed) begin
                m_armed   = 1'b1;
                m_timeout = 1'b0;
                m_match   = 0;
            end else begin
                p = idx - m_rise;
                if (m_match == 0 || p != int'(m_period)) m_match = 1;
                else if (m_match < LOCK_COUNT) m_match = m_match + 1;
                m_period = CNT_WIDTH'(p);
                m_high   = CNT_WIDTH'(m_fall - m_rise);
                m_valid  = 1'b1;
                m_locked = (m_match >= LOCK_COUNT);
            end
            m_rise = idx;
        end
        if (f) m_fall = idx;
        if (!r && m_armed && (idx - m_rise == TIMEOUT)) begin
            m_armed   = 1'b0;
            m_match   = 0;
            m_locked  = 1'b0;
            m_timeout = 1'b1;
        end
        m_prev = x;
        pipe.push_back('{period: m_period, high: m_high, valid: m_valid,
                         locked: m_locked, timeout: m_timeout});
        sig_in = x;
        idx++;
    endtask

    task automatic pulse(input int hi, input int lo);
        for (int k = 0; k < hi; k++) step(1'b1);
        for (int k = 0; k < lo; k++) step(1'b0);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        sig_in = 1'b0;
        #1;
        check("rst_period",    32'(period),    32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_valid",     32'(valid),     32'd0);
        check("rst_locked",    32'(locked),    32'd0);
        check("rst_timeout",   32'(timeout),   32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int h;
        int l;
        rst_n  = 1'b1;
        sig_in = 1'b0;
        #2;
        do_reset();

        // 4 high / 4 low: period 8, high 4, lock on 4th valid.
        repeat (8) pulse(4, 4);

        // clk/2 toggle.
        repeat (8) pulse(1, 1);

        // Asymmetric, then change rate: lock drops and recovers.
        repeat (6) pulse(3, 5);
        repeat (6) pulse(8, 8);

        // Loss of signal after lock, then restart.
        repeat (6) pulse(4, 4);
        repeat (TIMEOUT + 10) step(1'b0);
        repeat (6) pulse(4, 4);

        // Rise exactly at the last legal count, then one cycle too late.
        repeat (5) pulse(4, 4);
        pulse(4, TIMEOUT - 4);
        pulse(4, TIMEOUT - 3);
        repeat (5) pulse(4, 4);

        // Reset mid-period while locked.
        repeat (6) pulse(4, 4);
        check("locked_before_rst", 32'(locked), 32'd1);
        step(1'b1);
        step(1'b1);
        do_reset();
        repeat (8) pulse(4, 4);

        // Random square waves.
        repeat (6) begin
            h = int'($urandom_range(1, 12));
            l = int'($urandom_range(1, 12));
            repeat (int'($urandom_range(3, 7))) pulse(h, l);
        end

        // Random bit stream.
        repeat (300) step(1'($urandom_range(0, 1)));

        repeat (LAT + 2) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
